prng_rr_arbiter: RTL and testbench

//  Shares one Fibonacci LFSR pseudo-random source among NREQ requesters, round-robin.

---
 rtl/prng_rr_arbiter_pkg.sv | 23 ++
 rtl/prng_rr_arbiter_lfsr.sv | 39 +++
 rtl/prng_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_prng_rr_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/prng_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin PRNG arbiter: FSM encoding,
// default polynomial/seed, and the Fibonacci LFSR step function.
package prng_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    SERVE = 2'd2
  } state_t;

  localparam logic [3:0] DEFAULT_TAPS = 4'b1010;
  localparam logic [3:0] DEFAULT_SEED = 4'b0001;

  // Operates on a zero-extended state; callers truncate back to their width.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps);
    logic [31:0] nxt;
    nxt    = state << 1;
    nxt[0] = ^(state & taps);
    return nxt;
  endfunction

endpackage

// File: rtl/prng_rr_arbiter_lfsr.sv
// Fibonacci LFSR state register: load has priority over step, otherwise holds.
// An all-zero load value is replaced by SEED so the register can never lock up.
module lfsr_core #(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(prng_pkg::DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(prng_pkg::DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] state_o
);
  import prng_pkg::*;

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (load_val_i == '0) ? SEED : load_val_i;
    end else if (step_i) begin
      lfsr_d = WIDTH'(lfsr_next(32'(lfsr_q), 32'(TAPS)));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/prng_rr_arbiter.sv
// Round-robin sharing of one LFSR among NREQ requesters: one word per grant,
// registered one-hot grant one cycle after request; seed load pre-empts grants.
module prng_rr_arbiter #(
  parameter int               NREQ  = 4,
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(prng_pkg::DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(prng_pkg::DEFAULT_SEED)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_i,
  input  logic                     seed_load_i,
  input  logic [WIDTH-1:0]         seed_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic                     rnd_valid_o,
  output logic [WIDTH-1:0]         rnd_o,
  output logic [$clog2(NREQ)-1:0]  rnd_id_o,
  output logic [15:0]              words_o
);
  import prng_pkg::*;

  localparam int IDW = $clog2(NREQ);

  if (SEED == '0) begin : g_seed_chk
    $fatal(1, "prng_rr_arbiter: SEED must be nonzero");
  end

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic [IDW-1:0]   rnd_id_q, rnd_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [15:0]      words_q, words_d;

  logic [WIDTH-1:0] lfsr_state;
  logic             grant_en;
  logic             seed_en;
  logic [IDW-1:0]   winner;
  logic             found;
  int unsigned      idx;

  // Scan from the slot after the last winner, wrapping, so every active
  // requester is reached within NREQ grants.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, SERVE, prng_pkg::SEED: begin
        if (seed_load_i) begin
          state_d = prng_pkg::SEED;
        end else if (|req_i) begin
          state_d = SERVE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign seed_en  = (state_d == prng_pkg::SEED);
  assign grant_en = (state_d == SERVE) && found;

  always_comb begin
    gnt_d    = '0;
    rnd_d    = rnd_q;
    rnd_id_d = rnd_id_q;
    ptr_d    = ptr_q;
    words_d  = words_q;
    if (seed_en) begin
      words_d = '0;
    end else if (grant_en) begin
      gnt_d    = NREQ'(1) << winner;
      rnd_d    = lfsr_state;
      rnd_id_d = winner;
      ptr_d    = winner;
      if (words_q != 16'hFFFF) begin
        words_d = words_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rnd_q    <= '0;
      rnd_id_q <= '0;
      ptr_q    <= IDW'(NREQ - 1);
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rnd_q    <= rnd_d;
      rnd_id_q <= rnd_id_d;
      ptr_q    <= ptr_d;
      words_q  <= words_d;
    end
  end

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (seed_en),
    .load_val_i (seed_i),
    .step_i     (grant_en),
    .state_o    (lfsr_state)
  );

  assign gnt_o       = gnt_q;
  assign rnd_valid_o = |gnt_q;
  assign rnd_o       = rnd_q;
  assign rnd_id_o    = rnd_id_q;
  assign words_o     = words_q;

endmodule

// File: tb/tb_prng_rr_arbiter.sv
// Directed bench for prng_rr_arbiter with default parameters (NREQ=4, WIDTH=4,
// TAPS=1010, SEED=0001); expected words follow 0001,0010,0101,1010,0100,1000.
module tb_prng_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       seed_load;
  logic [3:0] seed;
  logic [3:0] gnt;
  logic       vld;
  logic [3:0] rnd;
  logic [1:0] id;
  logic [15:0] words;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prng_rr_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .seed_load_i (seed_load),
    .seed_i      (seed),
    .gnt_o       (gnt),
    .rnd_valid_o (vld),
    .rnd_o       (rnd),
    .rnd_id_o    (id),
    .words_o     (words)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    req       = 4'b0000;
    seed_load = 1'b0;
    seed      = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", vld); end
    checks++; if (rnd !== 4'b0000) begin errors++; $display("FAIL reset_rnd: got %b expected 0000", rnd); end
    checks++; if (id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", id); end
    checks++; if (words !== 16'd0) begin errors++; $display("FAIL reset_words: got %0d expected 0", words); end
    // Idle cycle with no request must not grant.
    tick();
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL idle_vld: got %b expected 0", vld); end
  endtask

  task automatic test_single_req();
    logic [3:0] exp_rnd [7];
    exp_rnd = '{4'b0001, 4'b0010, 4'b0101, 4'b1010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    req = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (rnd !== exp_rnd[i]) begin errors++; $display("FAIL single_rnd[%0d]: got %b expected %b", i, rnd, exp_rnd[i]); end
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt[%0d]: got %b expected 0001", i, gnt); end
      checks++; if (vld !== 1'b1) begin errors++; $display("FAIL single_vld[%0d]: got %b expected 1", i, vld); end
    end
    checks++; if (words !== 16'd7) begin errors++; $display("FAIL single_words: got %0d expected 7", words); end
  endtask

  task automatic test_all_req();
    logic [3:0] exp_rnd [8];
    logic [3:0] exp_gnt;
    logic [1:0] exp_id;
    exp_rnd = '{4'b0001, 4'b0010, 4'b0101, 4'b1010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_id  = 2'(i % 4);
      exp_gnt = 4'b0001 << exp_id;
      checks++; if (id !== exp_id) begin errors++; $display("FAIL all_id[%0d]: got %0d expected %0d", i, id, exp_id); end
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL all_gnt[%0d]: got %b expected %b", i, gnt, exp_gnt); end
      checks++; if (rnd !== exp_rnd[i]) begin errors++; $display("FAIL all_rnd[%0d]: got %b expected %b", i, rnd, exp_rnd[i]); end
    end
  endtask

  task automatic test_alt_req();
    logic [1:0] exp_ids [4];
    logic [3:0] exp_gnt;
    exp_ids = '{2'd0, 2'd2, 2'd0, 2'd2};
    apply_reset();
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_gnt = 4'b0001 << exp_ids[i];
      checks++; if (id !== exp_ids[i]) begin errors++; $display("FAIL alt_id[%0d]: got %0d expected %0d", i, id, exp_ids[i]); end
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL alt_gnt[%0d]: got %b expected %b", i, gnt, exp_gnt); end
    end
    checks++; if (words !== 16'd4) begin errors++; $display("FAIL alt_words: got %0d expected 4", words); end
  endtask

  // Continues from test_alt_req: last winner id 2, last word 1010.
  task automatic test_seed_load();
    req       = 4'b1111;
    seed      = 4'b1010;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL seed_vld: got %b expected 0", vld); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL seed_gnt: got %b expected 0000", gnt); end
    checks++; if (words !== 16'd0) begin errors++; $display("FAIL seed_words: got %0d expected 0", words); end
    checks++; if (id !== 2'd2) begin errors++; $display("FAIL seed_id_hold: got %0d expected 2", id); end
    tick();
    checks++; if (rnd !== 4'b1010) begin errors++; $display("FAIL seed_rnd: got %b expected 1010", rnd); end
    checks++; if (id !== 2'd3) begin errors++; $display("FAIL seed_next_id: got %0d expected 3", id); end
    checks++; if (words !== 16'd1) begin errors++; $display("FAIL seed_next_words: got %0d expected 1", words); end
  endtask

  task automatic test_zero_seed();
    seed      = 4'b0000;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL zseed_vld: got %b expected 0", vld); end
    tick();
    checks++; if (rnd !== 4'b0001) begin errors++; $display("FAIL zseed_rnd: got %b expected 0001", rnd); end
    checks++; if (id !== 2'd0) begin errors++; $display("FAIL zseed_id: got %0d expected 0", id); end
  endtask

  task automatic test_async_reset();
    req = 4'b1111;
    tick();
    checks++; if (id !== 2'd1) begin errors++; $display("FAIL areset_pre_id: got %0d expected 1", id); end
    checks++; if (rnd !== 4'b0010) begin errors++; $display("FAIL areset_pre_rnd: got %b expected 0010", rnd); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL areset_gnt: got %b expected 0000", gnt); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL areset_vld: got %b expected 0", vld); end
    checks++; if (rnd !== 4'b0000) begin errors++; $display("FAIL areset_rnd: got %b expected 0000", rnd); end
    checks++; if (id !== 2'd0) begin errors++; $display("FAIL areset_id: got %0d expected 0", id); end
    checks++; if (words !== 16'd0) begin errors++; $display("FAIL areset_words: got %0d expected 0", words); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++; if (id !== 2'd0) begin errors++; $display("FAIL areset_first_id: got %0d expected 0", id); end
    checks++; if (rnd !== 4'b0001) begin errors++; $display("FAIL areset_first_rnd: got %b expected 0001", rnd); end
    checks++; if (words !== 16'd1) begin errors++; $display("FAIL areset_first_words: got %0d expected 1", words); end
  endtask

  // Continues from test_async_reset with words_o = 1.
  task automatic test_saturation();
    req = 4'b0001;
    repeat (65533) tick();
    checks++; if (words !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h expected fffe", words); end
    tick();
    checks++; if (words !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h expected ffff", words); end
    tick();
    checks++; if (words !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", words); end
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL sat_vld: got %b expected 1", vld); end
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_all_req();
    test_alt_req();
    test_seed_load();
    test_zero_seed();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
